// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: modes, register map, STATUS bits
// and master-write FSM states.
package led_seq_pkg;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_PATTERN = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int unsigned STATUS_OVR_BIT  = 29;
    localparam int unsigned STATUS_DIR_BIT  = 30;
    localparam int unsigned STATUS_BUSY_BIT = 31;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_WRITE = 1'b1;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-period counter: emits a one-cycle tick every period+1 enabled cycles.
module led_seq_prescaler #(
    parameter int unsigned WIDTH = 26
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    output logic             tick
);

    logic [WIDTH-1:0] count_q, count_d;

    // >= rather than == so a PERIOD shrunk below the running count still ticks promptly
    assign tick = enable && (count_q >= period);

    always_comb begin
        count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        if (clear || !enable || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Autonomous LED pattern engine: CPU-configured slave registers, Avalon-MM master
// writes of the current pattern to the LED PIO on every load/step.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned LED_WIDTH      = 10,
    parameter int unsigned PRESCALE_WIDTH = 26,
    parameter int unsigned PERIOD_RESET   = 49999999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    logic                      en_q, en_d;
    logic [1:0]                mode_q;
    logic [PRESCALE_WIDTH-1:0] period_q;
    logic [LED_WIDTH-1:0]      pattern_q, cur_q, cur_d, nxt_cur, wdata_q, wdata_d;
    logic                      dir_q, dir_d, nxt_dir;
    logic                      ovr_q, ovr_d, pend_q, pend_d;
    logic                      state_q, state_d;
    logic                      s_wr, ctrl_wr, period_wr, pat_wr, status_wr;
    logic                      tick, load, step, req;
    logic [31:0]               status;
    logic                      unused_wdata;

    assign unused_wdata = ^s_writedata[31:PRESCALE_WIDTH];

    assign s_wr      = s_chipselect && !s_write_n;
    assign ctrl_wr   = s_wr && (s_address == REG_CTRL);
    assign period_wr = s_wr && (s_address == REG_PERIOD);
    assign pat_wr    = s_wr && (s_address == REG_PATTERN);
    assign status_wr = s_wr && (s_address == REG_STATUS);

    assign en_d = ctrl_wr ? s_writedata[0] : en_q;
    assign load = (ctrl_wr && s_writedata[0] && !en_q) || (pat_wr && en_q);
    // A disabling CTRL write suppresses a coincident step so nothing follows the in-flight write
    assign step = tick && !load && en_d;
    assign req  = load || (step && (mode_q != MODE_STATIC));

    led_seq_prescaler #(
        .WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (load),
        .enable  (en_q),
        .period  (period_q),
        .tick    (tick)
    );

    always_comb begin
        nxt_cur = cur_q;
        nxt_dir = dir_q;
        case (mode_q)
            MODE_ROTATE: nxt_cur = {cur_q[LED_WIDTH-2:0], cur_q[LED_WIDTH-1]};
            MODE_BOUNCE: begin
                if (!dir_q) begin
                    nxt_dir = cur_q[LED_WIDTH-1];
                    nxt_cur = cur_q[LED_WIDTH-1] ? (cur_q >> 1) : (cur_q << 1);
                end else begin
                    nxt_dir = !cur_q[0];
                    nxt_cur = cur_q[0] ? (cur_q << 1) : (cur_q >> 1);
                end
            end
            MODE_BLINK:  nxt_cur = (cur_q == '0) ? pattern_q : '0;
            default:     nxt_cur = cur_q;
        endcase
    end

    always_comb begin
        cur_d = cur_q;
        dir_d = dir_q;
        if (load) begin
            cur_d = pat_wr ? s_writedata[LED_WIDTH-1:0] : pattern_q;
            dir_d = 1'b0;
        end else if (step) begin
            cur_d = nxt_cur;
            dir_d = nxt_dir;
        end
    end

    // Write data is captured only on WRITE entry so it stays stable while stalled
    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        pend_d  = pend_q;
        ovr_d   = status_wr ? 1'b0 : ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_WRITE;
                    wdata_d = cur_d;
                end
            end
            default: begin
                if (!m_waitrequest) begin
                    pend_d = 1'b0;
                    if (en_d && (pend_q || req)) begin
                        wdata_d = cur_d;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (req) begin
                    if (pend_q) begin
                        ovr_d = 1'b1;
                    end
                    pend_d = 1'b1;
                end
            end
        endcase
        if (!en_d) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= 1'b0;
            mode_q    <= MODE_STATIC;
            period_q  <= PRESCALE_WIDTH'(PERIOD_RESET);
            pattern_q <= '0;
            cur_q     <= '0;
            dir_q     <= 1'b0;
            ovr_q     <= 1'b0;
            pend_q    <= 1'b0;
            state_q   <= ST_IDLE;
            wdata_q   <= '0;
        end else begin
            en_q      <= en_d;
            if (ctrl_wr) begin
                mode_q <= s_writedata[2:1];
            end
            if (period_wr) begin
                period_q <= s_writedata[PRESCALE_WIDTH-1:0];
            end
            if (pat_wr) begin
                pattern_q <= s_writedata[LED_WIDTH-1:0];
            end
            cur_q     <= cur_d;
            dir_q     <= dir_d;
            ovr_q     <= ovr_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        status                  = '0;
        status[LED_WIDTH-1:0]   = cur_q;
        status[STATUS_OVR_BIT]  = ovr_q;
        status[STATUS_DIR_BIT]  = dir_q;
        status[STATUS_BUSY_BIT] = (state_q == ST_WRITE);
        case (s_address)
            REG_CTRL:    s_readdata = {29'd0, mode_q, en_q};
            REG_PERIOD:  s_readdata = {{(32-PRESCALE_WIDTH){1'b0}}, period_q};
            REG_PATTERN: s_readdata = {{(32-LED_WIDTH){1'b0}}, pattern_q};
            default:     s_readdata = status;
        endcase
    end

    assign m_address    = 2'b00;
    assign m_chipselect = (state_q == ST_WRITE);
    assign m_write_n    = (state_q != ST_WRITE);
    assign m_writedata  = {{(32-LED_WIDTH){1'b0}}, wdata_q};

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer; a monitor records every
// accepted master write (data and cycle) for the scenario tasks to compare.
module tb_led_pattern_sequencer;

    localparam logic [31:0] PERIOD_RST = 32'd49999999;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  s_address = 2'd0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = 32'd0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [31:0] wq[$];
    int tq[$];

    led_pattern_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_chipselect  (s_chipselect),
        .s_write_n     (s_write_n),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && m_chipselect && !m_write_n && !m_waitrequest) begin
            wq.push_back(m_writedata);
            tq.push_back(cyc);
        end
    end

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        s_address = a;
        s_writedata = d;
        s_chipselect = 1'b1;
        s_write_n = 1'b0;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        #1;
        d = s_readdata;
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wq.size() < n; i++) @(negedge clk);
    endtask

    task automatic clear_log();
        wq.delete();
        tq.delete();
    endtask

    task automatic test_reset();
        logic [31:0] exp_r[4];
        logic [31:0] got;
        exp_r = '{32'd0, PERIOD_RST, 32'd0, 32'd0};
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_master got cs=%b wn=%b a=%0d d=%h", m_chipselect, m_write_n,
                     m_address, m_writedata);
        end
        for (int a = 0; a < 4; a++) begin
            cpu_read(2'(a), got);
            n_checks++;
            if (got !== exp_r[a]) begin
                n_fail++;
                $display("FAIL reset_reg%0d got=%h exp=%h", a, got, exp_r[a]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_registers();
        logic [31:0] got;
        clear_log();
        cpu_write(2'd2, 32'hFFFF_FFFF);
        cpu_read(2'd2, got);
        n_checks++;
        if (got !== 32'h0000_03FF) begin
            n_fail++;
            $display("FAIL pattern_unused_bits got=%h exp=%h", got, 32'h3FF);
        end
        cpu_write(2'd1, 32'hFFFF_FFFF);
        cpu_read(2'd1, got);
        n_checks++;
        if (got !== 32'h03FF_FFFF) begin
            n_fail++;
            $display("FAIL period_unused_bits got=%h exp=%h", got, 32'h03FF_FFFF);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (wq.size() !== 0) begin
            n_fail++;
            $display("FAIL no_write_when_disabled got=%0d exp=0", wq.size());
        end
    endtask

    task automatic test_rotate();
        logic [31:0] exp_w[3];
        logic [31:0] got;
        int d;
        exp_w = '{32'h001, 32'h002, 32'h004};
        cpu_write(2'd1, 32'd3);
        cpu_write(2'd2, 32'h001);
        clear_log();
        cpu_write(2'd0, 32'h3);
        n_checks++;
        if ({m_chipselect, m_write_n, m_writedata} !== {1'b1, 1'b0, 32'h001}) begin
            n_fail++;
            $display("FAIL rotate_load_write got cs=%b wn=%b d=%h exp 1 0 001", m_chipselect,
                     m_write_n, m_writedata);
        end
        wait_writes(3, 30);
        for (int k = 0; k < 3; k++) begin
            got = (wq.size() > k) ? wq[k] : 32'hxxxx_xxxx;
            n_checks++;
            if (got !== exp_w[k]) begin
                n_fail++;
                $display("FAIL rotate_write%0d got=%h exp=%h", k, got, exp_w[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            d = (tq.size() > k + 1) ? tq[k+1] - tq[k] : -1;
            n_checks++;
            if (d !== 4) begin
                n_fail++;
                $display("FAIL rotate_interval%0d got=%0d exp=4", k, d);
            end
        end
        cpu_read(2'd3, got);
        n_checks++;
        if (got[9:0] !== 10'h004) begin
            n_fail++;
            $display("FAIL rotate_status_cur got=%h exp=%h", got[9:0], 10'h004);
        end
        cpu_write(2'd0, 32'h2);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bounce();
        logic [31:0] exp_w[4];
        logic [31:0] got;
        int d;
        exp_w = '{32'h100, 32'h200, 32'h100, 32'h080};
        cpu_write(2'd1, 32'd0);
        cpu_write(2'd2, 32'h100);
        clear_log();
        cpu_write(2'd0, 32'h5);
        wait_writes(4, 20);
        cpu_read(2'd3, got);
        n_checks++;
        if (got[30] !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_dir got=%b exp=1", got[30]);
        end
        cpu_write(2'd0, 32'h4);
        for (int k = 0; k < 4; k++) begin
            got = (wq.size() > k) ? wq[k] : 32'hxxxx_xxxx;
            n_checks++;
            if (got !== exp_w[k]) begin
                n_fail++;
                $display("FAIL bounce_write%0d got=%h exp=%h", k, got, exp_w[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            d = (tq.size() > k + 1) ? tq[k+1] - tq[k] : -1;
            n_checks++;
            if (d !== 1) begin
                n_fail++;
                $display("FAIL bounce_back_to_back%0d got=%0d exp=1", k, d);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_blink();
        logic [31:0] exp_w[3];
        logic [31:0] got;
        exp_w = '{32'h155, 32'h000, 32'h155};
        cpu_write(2'd1, 32'd1);
        cpu_write(2'd2, 32'h155);
        clear_log();
        cpu_write(2'd0, 32'h7);
        wait_writes(3, 20);
        cpu_write(2'd0, 32'h6);
        for (int k = 0; k < 3; k++) begin
            got = (wq.size() > k) ? wq[k] : 32'hxxxx_xxxx;
            n_checks++;
            if (got !== exp_w[k]) begin
                n_fail++;
                $display("FAIL blink_write%0d got=%h exp=%h", k, got, exp_w[k]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_static();
        logic [31:0] got;
        cpu_write(2'd1, 32'd0);
        cpu_write(2'd2, 32'h0AA);
        clear_log();
        cpu_write(2'd0, 32'h1);
        repeat (12) @(negedge clk);
        got = (wq.size() > 0) ? wq[0] : 32'hxxxx_xxxx;
        n_checks++;
        if (wq.size() !== 1 || got !== 32'h0AA) begin
            n_fail++;
            $display("FAIL static_single_write got n=%0d d=%h exp n=1 d=0aa", wq.size(), got);
        end
        cpu_write(2'd0, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overrun();
        logic [31:0] got;
        cpu_write(2'd1, 32'd1);
        cpu_write(2'd2, 32'h001);
        clear_log();
        m_waitrequest = 1'b1;
        cpu_write(2'd0, 32'h3);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({m_chipselect, m_write_n, m_writedata} !== {1'b1, 1'b0, 32'h001}) begin
                n_fail++;
                $display("FAIL overrun_stable_c%0d got cs=%b wn=%b d=%h exp 1 0 001", i,
                         m_chipselect, m_write_n, m_writedata);
            end
            @(negedge clk);
        end
        cpu_read(2'd3, got);
        n_checks++;
        if ({got[31], got[29], got[9:0]} !== {1'b1, 1'b1, 10'h020}) begin
            n_fail++;
            $display("FAIL overrun_status got busy=%b ovr=%b cur=%h exp 1 1 020", got[31], got[29],
                     got[9:0]);
        end
        m_waitrequest = 1'b0;
        wait_writes(2, 10);
        cpu_write(2'd0, 32'h2);
        got = (wq.size() > 0) ? wq[0] : 32'hxxxx_xxxx;
        n_checks++;
        if (got !== 32'h001) begin
            n_fail++;
            $display("FAIL overrun_first got=%h exp=001", got);
        end
        got = (wq.size() > 1) ? wq[1] : 32'hxxxx_xxxx;
        n_checks++;
        if (got !== 32'h020) begin
            n_fail++;
            $display("FAIL overrun_latest got=%h exp=020", got);
        end
        repeat (4) @(negedge clk);
        cpu_write(2'd3, 32'h0);
        cpu_read(2'd3, got);
        n_checks++;
        if (got[29] !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear got=%b exp=0", got[29]);
        end
    endtask

    task automatic test_disable_mid_write();
        logic [31:0] got;
        cpu_write(2'd1, 32'd3);
        cpu_write(2'd2, 32'h001);
        clear_log();
        m_waitrequest = 1'b1;
        cpu_write(2'd0, 32'h3);
        cpu_write(2'd0, 32'h2);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({m_chipselect, m_writedata} !== {1'b1, 32'h001}) begin
                n_fail++;
                $display("FAIL disable_inflight_c%0d got cs=%b d=%h exp 1 001", i, m_chipselect,
                         m_writedata);
            end
            @(negedge clk);
        end
        m_waitrequest = 1'b0;
        repeat (20) @(negedge clk);
        cpu_read(2'd3, got);
        n_checks++;
        if (wq.size() !== 1 || m_chipselect !== 1'b0 || got[31] !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_no_more got n=%0d cs=%b busy=%b exp 1 0 0", wq.size(),
                     m_chipselect, got[31]);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] exp_r[4];
        logic [31:0] got;
        exp_r = '{32'd0, PERIOD_RST, 32'd0, 32'd0};
        cpu_write(2'd2, 32'h2AA);
        clear_log();
        m_waitrequest = 1'b1;
        cpu_write(2'd0, 32'h3);
        n_checks++;
        if (m_chipselect !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_write got cs=%b exp=1", m_chipselect);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({m_chipselect, m_write_n, m_writedata} !== {1'b0, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL rst_async_drop got cs=%b wn=%b d=%h exp 0 1 0", m_chipselect,
                     m_write_n, m_writedata);
        end
        for (int a = 0; a < 4; a++) begin
            cpu_read(2'(a), got);
            n_checks++;
            if (got !== exp_r[a]) begin
                n_fail++;
                $display("FAIL rst_mid_reg%0d got=%h exp=%h", a, got, exp_r[a]);
            end
        end
        @(negedge clk);
        m_waitrequest = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wq.size() !== 0) begin
            n_fail++;
            $display("FAIL rst_no_write got=%0d exp=0", wq.size());
        end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_rotate();
        test_bounce();
        test_blink();
        test_static();
        test_overrun();
        test_disable_mid_write();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
